// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
// pipeline. Holds the PC, presents it to instruction memory as the fetch
// address, and latches the returned instruction with its PC and PC+4 into
// IF/ID for the decode stage.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   PC_write       0 = hold PC (load-use stall from hazard unit)
//   IF_ID_write    0 = hold IF/ID contents (load-use stall from hazard unit)
//   branch_taken   taken branch resolved downstream, redirect to branch_target
//   branch_target  branch destination
//   jump           jump decoded in ID, redirect to jump_target
//   jump_target    jump destination
//   imem_addr      fetch address, always equal to the PC register
//   imem_req       fetch request, high whenever reset is low
//   imem_rdata     instruction returned for imem_addr
//   imem_ready     imem_rdata is valid this cycle
//   pc_ID          PC of the instruction held in IF/ID
//   pc_plus4_ID    PC+4 of the instruction held in IF/ID
//   instr_ID       instruction held in IF/ID
//   valid_ID       IF/ID holds a real instruction (0 = bubble)
//   fetch_stall    registered: previous cycle's fetch was not accepted
// ---------------------------------------------------------------------------
module if_stage #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PC_write,
   input  logic              IF_ID_write,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] pc_ID,
   output logic [ADDR_W-1:0] pc_plus4_ID,
   output logic [31:0]       instr_ID,
   output logic              valid_ID,
   output logic              fetch_stall
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_pc;
   logic              redirect;
   logic              accept;

   // Wrapping add; low address bits pass through untouched, no alignment check.
   assign pc_plus4    = pc + ADDR_W'(4);

   // The older instruction (the resolved branch) wins over a younger jump.
   assign redirect    = branch_taken | jump;
   assign redirect_pc = branch_taken ? branch_target : jump_target;

   // An instruction is consumed only when memory delivers it and neither
   // pipeline-hold control blocks the stage.
   assign accept      = imem_ready & PC_write & IF_ID_write;

   assign imem_addr   = pc;
   assign imem_req    = ~reset;

   // PC register. A redirect beats any stall or memory wait; otherwise the
   // PC only moves forward when the current fetch is actually returned and
   // PC_write allows it. With IF_ID_write low but PC_write high the PC still
   // advances and that fetched instruction is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (PC_write && imem_ready) begin
         pc <= pc_plus4;
      end
   end

   // IF/ID register. Redirects and memory waits insert a bubble, a load-use
   // stall freezes every field. If PC_write alone is low the returned
   // instruction is not consumed (PC holds), so a bubble is loaded rather
   // than a copy that would be fetched again next cycle.
   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         pc_ID       <= '0;
         pc_plus4_ID <= '0;
         instr_ID    <= NOP_INSTR;
         valid_ID    <= 1'b0;
      end else if (IF_ID_write) begin
         if (accept) begin
            pc_ID       <= pc;
            pc_plus4_ID <= pc_plus4;
            instr_ID    <= imem_rdata;
            valid_ID    <= 1'b1;
         end else begin
            pc_ID       <= '0;
            pc_plus4_ID <= '0;
            instr_ID    <= NOP_INSTR;
            valid_ID    <= 1'b0;
         end
      end
   end

   // Records that the fetch issued last cycle was left waiting on memory.
   // An abandoned fetch (redirect) is not counted as a wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_stall <= 1'b0;
      end else begin
         fetch_stall <= ~redirect & ~imem_ready & imem_req;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed testbench for if_stage: each step drives one cycle of controls,
// clocks the DUT, and compares outputs 1 time unit after the rising edge
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        PC_write;
   logic        IF_ID_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc_ID;
   logic [31:0] pc_plus4_ID;
   logic [31:0] instr_ID;
   logic        valid_ID;
   logic        fetch_stall;

   int checkCount;
   int failCount;

   if_stage dut (
      .clk           (clk),
      .reset         (reset),
      .PC_write      (PC_write),
      .IF_ID_write   (IF_ID_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_addr     (imem_addr),
      .imem_req      (imem_req),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .pc_ID         (pc_ID),
      .pc_plus4_ID   (pc_plus4_ID),
      .instr_ID      (instr_ID),
      .valid_ID      (valid_ID),
      .fetch_stall   (fetch_stall)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, clocks the DUT and settles past the edge.
   task automatic applyStimulus(input logic pcw, input logic ifw,
                                input logic bt, input logic [31:0] btg,
                                input logic jp, input logic [31:0] jtg,
                                input logic rdy, input logic [31:0] rdata);
      PC_write      = pcw;
      IF_ID_write   = ifw;
      branch_taken  = bt;
      branch_target = btg;
      jump          = jp;
      jump_target   = jtg;
      imem_ready    = rdy;
      imem_rdata    = rdata;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      reset      = 1'b1;

      // Reset state, sampled while reset is still asserted.
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'hAAAA_AAAA);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_valid", 32'(valid_ID), 32'h0);
      checkOutput("rst_instr", instr_ID, 32'h0);
      checkOutput("rst_pc_ID", pc_ID, 32'h0);
      checkOutput("rst_pc4_ID", pc_plus4_ID, 32'h0);
      checkOutput("rst_stall", 32'(fetch_stall), 32'h0);
      checkOutput("rst_req", 32'(imem_req), 32'h0);
      reset = 1'b0;
      #1;
      checkOutput("req_after_rst", 32'(imem_req), 32'h1);

      // Four straight-line fetches from address 0.
      for (int i = 0; i < 4; i++) begin
         checkOutput("seq_addr_pre", imem_addr, 32'(4 * i));
         applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h2008_0001 + 32'(i));
         checkOutput("seq_instr", instr_ID, 32'h2008_0001 + 32'(i));
         checkOutput("seq_pc_ID", pc_ID, 32'(4 * i));
         checkOutput("seq_pc4_ID", pc_plus4_ID, 32'(4 * i + 4));
         checkOutput("seq_valid", 32'(valid_ID), 32'h1);
      end
      checkOutput("seq_addr_end", imem_addr, 32'h10);

      // Load-use stall at PC 0x10: everything holds for one cycle.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_0000);
      checkOutput("lu_addr", imem_addr, 32'h10);
      checkOutput("lu_instr", instr_ID, 32'h2008_0004);
      checkOutput("lu_pc_ID", pc_ID, 32'hC);
      checkOutput("lu_valid", 32'(valid_ID), 32'h1);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h1111_0010);
      checkOutput("lu_resume_pc_ID", pc_ID, 32'h10);
      checkOutput("lu_resume_instr", instr_ID, 32'h1111_0010);
      checkOutput("lu_resume_addr", imem_addr, 32'h14);

      // PC_write=1 with IF_ID_write=0: PC advances, fetched word dropped.
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hBAD0_0014);
      checkOutput("drop_addr", imem_addr, 32'h18);
      checkOutput("drop_pc_ID", pc_ID, 32'h10);
      checkOutput("drop_instr", instr_ID, 32'h1111_0010);

      // Branch and jump together with PC_write=0: branch wins, bubble.
      applyStimulus(0, 1, 1, 32'h40, 1, 32'h80, 1, 32'hBAD0_0018);
      checkOutput("br_addr", imem_addr, 32'h40);
      checkOutput("br_valid", 32'(valid_ID), 32'h0);
      checkOutput("br_instr", instr_ID, 32'h0);
      checkOutput("br_pc_ID", pc_ID, 32'h0);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h2222_0040);
      checkOutput("br_tgt_pc_ID", pc_ID, 32'h40);
      checkOutput("br_tgt_valid", 32'(valid_ID), 32'h1);
      checkOutput("br_tgt_addr", imem_addr, 32'h44);

      // Jump to 0x8 with memory not ready: abandoned fetch is not a wait.
      applyStimulus(1, 1, 0, 0, 1, 32'h8, 0, 32'hBAD0_0044);
      checkOutput("jp_addr", imem_addr, 32'h8);
      checkOutput("jp_stall", 32'(fetch_stall), 32'h0);
      checkOutput("jp_valid", 32'(valid_ID), 32'h0);

      // Three cycles of memory wait at 0x8.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'hBAD0_0008);
         checkOutput("wait_addr", imem_addr, 32'h8);
         checkOutput("wait_valid", 32'(valid_ID), 32'h0);
         checkOutput("wait_stall", 32'(fetch_stall), 32'h1);
      end
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h3333_0008);
      checkOutput("wait_done_pc_ID", pc_ID, 32'h8);
      checkOutput("wait_done_valid", 32'(valid_ID), 32'h1);
      checkOutput("wait_done_instr", instr_ID, 32'h3333_0008);
      checkOutput("wait_done_stall", 32'(fetch_stall), 32'h0);
      checkOutput("wait_done_addr", imem_addr, 32'hC);

      // PC+4 wrap at the top of the address space.
      applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_000C);
      checkOutput("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h4444_0000);
      checkOutput("wrap_pc_ID", pc_ID, 32'hFFFF_FFFC);
      checkOutput("wrap_pc4_ID", pc_plus4_ID, 32'h0);
      checkOutput("wrap_addr", imem_addr, 32'h0);

      // Reset in the middle of a combined load-use and memory stall.
      applyStimulus(1, 1, 0, 0, 1, 32'h20, 1, 32'hBAD0_0000);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h5555_0020);
      checkOutput("pre_rst_valid", 32'(valid_ID), 32'h1);
      checkOutput("pre_rst_addr", imem_addr, 32'h24);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'hBAD0_0024);
      checkOutput("hold_valid", 32'(valid_ID), 32'h1);
      checkOutput("hold_stall", 32'(fetch_stall), 32'h1);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'hBAD0_0024);
      checkOutput("mid_rst_addr", imem_addr, 32'h0);
      checkOutput("mid_rst_valid", 32'(valid_ID), 32'h0);
      checkOutput("mid_rst_stall", 32'(fetch_stall), 32'h0);
      checkOutput("mid_rst_pc_ID", pc_ID, 32'h0);
      checkOutput("mid_rst_req", 32'(imem_req), 32'h0);
      reset = 1'b0;
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h6666_0000);
      checkOutput("post_rst_pc_ID", pc_ID, 32'h0);
      checkOutput("post_rst_instr", instr_ID, 32'h6666_0000);
      checkOutput("post_rst_addr", imem_addr, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of ID.
- Owns the PC, issues fetch addresses to instruction memory, and captures instruction plus PC+4 into IF/ID.
- Obeys the load-use stall controls PC_write and IF_ID_write produced by the hazard detection unit.
- Applies branch/jump redirects with a flush, and inserts bubbles when instruction memory is not ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding placed in IF/ID on bubble/flush (sll $0,$0,0).
- ADDR_W, 32, PC / address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- PC_write  input  1  0 = hold PC (load-use stall)
- IF_ID_write  input  1  0 = hold IF/ID contents (load-use stall)
- branch_taken  input  1  taken branch resolved downstream; redirect to branch_target
- branch_target  input  ADDR_W  branch destination
- jump  input  1  jump decoded in ID; redirect to jump_target
- jump_target  input  ADDR_W  jump destination
- imem_addr  output  ADDR_W  fetch address; equals PC (combinational)
- imem_req  output  1  fetch request; 1 whenever not in reset
- imem_rdata  input  32  instruction returned for imem_addr
- imem_ready  input  1  imem_rdata valid this cycle
- pc_ID  output  ADDR_W  PC of instruction in IF/ID
- pc_plus4_ID  output  ADDR_W  PC+4 of instruction in IF/ID
- instr_ID  output  32  instruction in IF/ID
- valid_ID  output  1  IF/ID holds a real instruction
- fetch_stall  output  1  registered: 1 while the previous cycle's fetch was not accepted (imem wait)

Behaviour:
- Reset (sync, on the clock edge with reset=1), all outputs:
  - PC = RESET_PC
  - instr_ID = NOP_INSTR
  - pc_ID = 0
  - pc_plus4_ID = 0
  - valid_ID = 0
  - fetch_stall = 0
- During reset, imem_req = 0.
- Reset mid-operation discards any pending fetch or stall; the first fetch after reset deassertion is at RESET_PC.
- Fetch is combinational: imem_addr = PC. An instruction is accepted in the cycle imem_ready = 1.
- PC+4 arithmetic: ADDR_W-bit add, wraps modulo 2^ADDR_W (32'hFFFF_FFFC + 4 = 0). No alignment check; low 2 bits pass through unchanged.
- Per-edge priority, highest first:
  1. reset.
  2. redirect (branch_taken or jump).
     - PC <= branch_target if branch_taken, else jump_target. branch_taken beats jump when both are set (older instruction wins).
     - IF/ID <= bubble: instr NOP_INSTR, valid 0, pc/pc_plus4 0.
     - Redirect overrides PC_write = 0, IF_ID_write = 0 and imem_ready = 0; an in-flight fetch is abandoned.
  3. load-use stall (IF_ID_write = 0): IF/ID holds all fields.
     - PC holds if PC_write = 0; otherwise it follows the rule for case 4 or 5.
  4. imem not ready (imem_ready = 0).
     - PC holds.
     - If IF_ID_write = 1, IF/ID <= bubble.
  5. normal (PC_write = 1, IF_ID_write = 1, imem_ready = 1).
     - PC <= PC+4.
     - IF/ID <= {PC, PC+4, imem_rdata, valid 1}.
- PC_write = 1 with IF_ID_write = 0 is legal: PC advances and the fetched instruction is dropped. The hazard unit never produces this; verification checks it anyway.
- fetch_stall <= ~reset & ~redirect & ~imem_ready & imem_req.
- Latency: an instruction accepted at edge N appears on instr_ID after edge N. Redirect to first valid_ID of the target takes 2 edges with imem_ready = 1.
- No combinational path from inputs to IF/ID outputs. imem_addr depends only on PC state.

Test Plan:
- Reset then 4 cycles with imem_ready = 1 and imem_rdata = 0x20080001.. → imem_addr 0, 4, 8, C. valid_ID = 1 from the 1st edge; pc_plus4_ID = 4, 8, C.
- PC = 0x10, PC_write = 0, IF_ID_write = 0 for 1 cycle → imem_addr stays 0x10; instr_ID/pc_ID unchanged for 1 cycle; the next cycle fetches 0x10 and resumes at 0x14.
- branch_taken = 1, branch_target = 0x40, in the same cycle as PC_write = 0 and jump = 1 with jump_target = 0x80 → next PC = 0x40; valid_ID = 0 and instr_ID = 0; the following edge loads pc_ID = 0x40.
- imem_ready = 0 for 3 cycles at PC = 0x8 → PC holds 0x8; valid_ID = 0 for 3 edges; fetch_stall = 1; on ready, pc_ID = 0x8 and valid_ID = 1.
- PC = 0xFFFF_FFFC, normal fetch → pc_plus4_ID = 0 and next imem_addr = 0. Assert reset mid-stall → PC = RESET_PC and valid_ID = 0 on the next edge.
